// File: rtl/sar_pkg.sv
// Shared definitions for the successive-approximation search controller.
// Latency: n/a (constants, types and a width helper only).
// Backpressure: n/a.
package sar_pkg;

  localparam int SAR_WIDTH_DEF   = 4;
  localparam int SAR_CMP_LAT_DEF = 1;

  typedef logic [1:0] sar_state_t;

  localparam sar_state_t ST_IDLE   = 2'd0;
  localparam sar_state_t ST_WAIT   = 2'd1;
  localparam sar_state_t ST_SAMPLE = 2'd2;
  localparam sar_state_t ST_DONE   = 2'd3;

  // A search issues at most WIDTH+1 probes, so STEPS must hold WIDTH+1.
  function automatic int steps_width(input int width);
    return $clog2(width + 2);
  endfunction

endpackage

// File: rtl/sar_probe_calc.sv
// Bound update and next-probe calculation for one lt/gt comparator outcome.
// Latency: purely combinational.
// Backpressure: none.
module sar_probe_calc #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH:0]   lo,
  input  logic [WIDTH:0]   hi,
  input  logic [WIDTH-1:0] probe_cur,
  input  logic             take_lt,
  output logic [WIDTH:0]   lo_nxt,
  output logic [WIDTH:0]   hi_nxt,
  output logic [WIDTH-1:0] probe_nxt,
  output logic             empty
);

  logic [WIDTH:0] probe_ext;
  logic [WIDTH:0] span;
  logic [WIDTH:0] mid;

  // Narrow the window on the side the comparator ruled out, then pick its midpoint.
  // hi only legitimately reaches 2^WIDTH-1, so its top bit set means it went to -1
  // (probe 0 reported too high) and the window is empty rather than wrapped.
  always_comb begin
    probe_ext = {1'b0, probe_cur};
    lo_nxt    = lo;
    hi_nxt    = hi;
    if (take_lt) begin
      hi_nxt = probe_ext - {{WIDTH{1'b0}}, 1'b1};
    end else begin
      lo_nxt = probe_ext + {{WIDTH{1'b0}}, 1'b1};
    end
    empty     = hi_nxt[WIDTH] | (lo_nxt > hi_nxt);
    span      = hi_nxt - lo_nxt;
    mid       = lo_nxt + (span >> 1);
    probe_nxt = mid[WIDTH-1:0];
  end

endmodule

// File: rtl/sar_search_ctrl.sv
// Binary-search driver for a registered magnitude comparator; optional macro SAR_FLAG_CHECK_EN.
// Latency: CMP_LAT+1 cycles per probe; DONE rises N*(CMP_LAT+1)+1 edges after START is launched.
// Backpressure: none; START is ignored while BUSY, results hold until next START or RST.
module sar_search_ctrl
  import sar_pkg::*;
#(
  parameter int WIDTH   = SAR_WIDTH_DEF,
  parameter int CMP_LAT = SAR_CMP_LAT_DEF
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic                             START,
  input  logic                             A_lt_B,
  input  logic                             A_gt_B,
  input  logic                             A_eq_B,
  output logic [WIDTH-1:0]                 B_OUT,
  output logic                             BUSY,
  output logic                             DONE,
  output logic                             FOUND,
  output logic [WIDTH-1:0]                 RESULT,
  output logic [steps_width(WIDTH)-1:0]    STEPS,
  output logic                             ERR
);

  localparam int SW = steps_width(WIDTH);
  // CMP_LAT is limited to 1..7, so the wait counter never exceeds 6.
  localparam logic [2:0]       LAT_RELOAD = 3'(CMP_LAT - 1);
  localparam logic [WIDTH:0]   HI_INIT    = {1'b0, {WIDTH{1'b1}}};
  localparam logic [WIDTH-1:0] PROBE_INIT = {1'b0, {(WIDTH-1){1'b1}}};

  sar_state_t     state;
  logic [2:0]     cnt;
  logic [WIDTH:0] lo;
  logic [WIDTH:0] hi;

  logic [WIDTH:0]   lo_nxt;
  logic [WIDTH:0]   hi_nxt;
  logic [WIDTH-1:0] probe_nxt;
  logic             empty;
  logic             flag_bad;

  logic launch;
  assign launch = START && ((state == ST_IDLE) || (state == ST_DONE));

  // Flag sanity: with checking on, anything but exactly one flag is a fault.
`ifdef SAR_FLAG_CHECK_EN
  always_comb begin
    flag_bad = 1'b1;
    case ({A_lt_B, A_gt_B, A_eq_B})
      3'b100, 3'b010, 3'b001: flag_bad = 1'b0;
      default:                flag_bad = 1'b1;
    endcase
  end
`else
  assign flag_bad = 1'b0;
`endif

  // eq has already won by the time the bound update is applied; lt beats gt,
  // and an all-zero flag set falls through to the gt branch.
  sar_probe_calc #(.WIDTH(WIDTH)) u_calc (
    .lo        (lo),
    .hi        (hi),
    .probe_cur (B_OUT),
    .take_lt   (A_lt_B),
    .lo_nxt    (lo_nxt),
    .hi_nxt    (hi_nxt),
    .probe_nxt (probe_nxt),
    .empty     (empty)
  );

  // Search FSM: launch, wait out comparator latency, sample and refine or finish.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= ST_IDLE;
      cnt    <= 3'd0;
      lo     <= '0;
      hi     <= '0;
      B_OUT  <= '0;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
      FOUND  <= 1'b0;
      RESULT <= '0;
      STEPS  <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (launch) begin
            lo    <= '0;
            hi    <= HI_INIT;
            B_OUT <= PROBE_INIT;
            STEPS <= SW'(1);
            cnt   <= LAT_RELOAD;
            BUSY  <= 1'b1;
            DONE  <= 1'b0;
            FOUND <= 1'b0;
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt == 3'd0) begin
            state <= ST_SAMPLE;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        ST_SAMPLE: begin
          if (flag_bad) begin
            FOUND <= 1'b0;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
            state <= ST_DONE;
          end else if (A_eq_B) begin
            RESULT <= B_OUT;
            FOUND  <= 1'b1;
            BUSY   <= 1'b0;
            DONE   <= 1'b1;
            state  <= ST_DONE;
          end else begin
            lo <= lo_nxt;
            hi <= hi_nxt;
            if (empty) begin
              FOUND <= 1'b0;
              BUSY  <= 1'b0;
              DONE  <= 1'b1;
              state <= ST_DONE;
            end else begin
              B_OUT <= probe_nxt;
              STEPS <= STEPS + SW'(1);
              cnt   <= LAT_RELOAD;
              state <= ST_WAIT;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef SAR_FLAG_CHECK_EN
  logic err_q;

  // Sticky flag-fault indicator, cleared by reset or a new search.
  always_ff @(posedge CLK) begin
    if (RST) begin
      err_q <= 1'b0;
    end else if (launch) begin
      err_q <= 1'b0;
    end else if ((state == ST_SAMPLE) && flag_bad) begin
      err_q <= 1'b1;
    end
  end

  assign ERR = err_q;
`else
  assign ERR = 1'b0;
`endif

endmodule

// File: tb/tb_sar_search_ctrl.sv
// Directed bench for sar_search_ctrl driving a registered comparator model.
// Latency: comparator model has one cycle of latency.
// Backpressure: n/a.
module tb_sar_search_ctrl;

  logic       CLK;
  logic       RST;
  logic       START;
  logic       A_lt_B;
  logic       A_gt_B;
  logic       A_eq_B;
  logic [3:0] B_OUT;
  logic       BUSY;
  logic       DONE;
  logic       FOUND;
  logic [3:0] RESULT;
  logic [2:0] STEPS;
  logic       ERR;

  int total;
  int bad;

  logic [3:0] target;
  int         mode;       // 0: true compare, 1: always lt, 2: lt and gt together
  logic [3:0] probes [0:7];
  int         nprobes;
  int         done_cyc;

  sar_search_ctrl #(.WIDTH(4), .CMP_LAT(1)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .START  (START),
    .A_lt_B (A_lt_B),
    .A_gt_B (A_gt_B),
    .A_eq_B (A_eq_B),
    .B_OUT  (B_OUT),
    .BUSY   (BUSY),
    .DONE   (DONE),
    .FOUND  (FOUND),
    .RESULT (RESULT),
    .STEPS  (STEPS),
    .ERR    (ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Registered comparator: A = target, B = B_OUT, one cycle to valid flags.
  always @(posedge CLK) begin
    case (mode)
      1:       {A_lt_B, A_gt_B, A_eq_B} <= 3'b100;
      2:       {A_lt_B, A_gt_B, A_eq_B} <= 3'b110;
      default: {A_lt_B, A_gt_B, A_eq_B} <= {target < B_OUT, target > B_OUT, target == B_OUT};
    endcase
  end

  // Launch a search and record each probe plus the edge count at which DONE rose.
  task automatic run_search(input logic [3:0] tgt, input int md, input int poke_at);
    int         cyc;
    logic [2:0] last;
    target   = tgt;
    mode     = md;
    nprobes  = 0;
    done_cyc = -1;
    START    = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    cyc   = 1;
    probes[0] = B_OUT;
    nprobes   = 1;
    last      = STEPS;
    if (DONE) done_cyc = cyc;
    while (cyc < 60 && !DONE) begin
      if (cyc == poke_at) START = 1'b1;
      @(posedge CLK); #1;
      START = 1'b0;
      cyc++;
      if (STEPS != last && nprobes < 8) begin
        probes[nprobes] = B_OUT;
        nprobes++;
        last = STEPS;
      end
      if (DONE) done_cyc = cyc;
    end
  endtask

  task automatic test_reset;
    RST = 1'b1;
    START = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    total++;
    if ({B_OUT, BUSY, DONE, FOUND, RESULT, STEPS, ERR} !== 15'd0) begin
      bad++;
      $display("FAIL reset_outputs: got B=%h busy=%b done=%b found=%b res=%h steps=%0d err=%b, want all 0",
               B_OUT, BUSY, DONE, FOUND, RESULT, STEPS, ERR);
    end
    RST = 1'b0;
    @(posedge CLK); #1;
    total++;
    if (DONE !== 1'b0 || BUSY !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_reset: got busy=%b done=%b, want 0 0", BUSY, DONE);
    end
  endtask

  task automatic test_find(input string name, input logic [3:0] tgt,
                           input int exp_n, input logic [31:0] exp_seq, input int exp_cyc);
    logic [3:0] e;
    run_search(tgt, 0, -1);
    total++;
    if (done_cyc !== exp_cyc) begin
      bad++;
      $display("FAIL %s done_cycle: got %0d want %0d", name, done_cyc, exp_cyc);
    end
    total++;
    if (nprobes !== exp_n) begin
      bad++;
      $display("FAIL %s probe_count: got %0d want %0d", name, nprobes, exp_n);
    end
    for (int i = 0; i < exp_n && i < nprobes; i++) begin
      e = exp_seq[4*(exp_n-1-i) +: 4];
      total++;
      if (probes[i] !== e) begin
        bad++;
        $display("FAIL %s probe%0d: got %h want %h", name, i, probes[i], e);
      end
    end
    total++;
    if ({DONE, BUSY, FOUND, RESULT, STEPS, ERR} !== {1'b1, 1'b0, 1'b1, tgt, 3'(exp_n), 1'b0}) begin
      bad++;
      $display("FAIL %s status: got done=%b busy=%b found=%b res=%h steps=%0d err=%b, want 1 0 1 %h %0d 0",
               name, DONE, BUSY, FOUND, RESULT, STEPS, ERR, tgt, exp_n);
    end
    // Outputs stay frozen while sitting in DONE.
    repeat (3) @(posedge CLK);
    #1;
    total++;
    if (DONE !== 1'b1 || RESULT !== tgt) begin
      bad++;
      $display("FAIL %s hold: got done=%b res=%h want 1 %h", name, DONE, RESULT, tgt);
    end
  endtask

  task automatic test_always_lt;
    logic [15:0] seq;
    logic [3:0]  e;
    seq = 16'h7310;
    run_search(4'h5, 1, -1);
    total++;
    if (nprobes !== 4 || done_cyc !== 9) begin
      bad++;
      $display("FAIL always_lt shape: got probes=%0d done_cyc=%0d want 4 9", nprobes, done_cyc);
    end
    for (int i = 0; i < 4 && i < nprobes; i++) begin
      e = seq[4*(3-i) +: 4];
      total++;
      if (probes[i] !== e) begin
        bad++;
        $display("FAIL always_lt probe%0d: got %h want %h", i, probes[i], e);
      end
    end
    total++;
    if ({DONE, BUSY, FOUND, STEPS} !== {1'b1, 1'b0, 1'b0, 3'd4}) begin
      bad++;
      $display("FAIL always_lt status: got done=%b busy=%b found=%b steps=%0d want 1 0 0 4",
               DONE, BUSY, FOUND, STEPS);
    end
  endtask

  task automatic test_start_while_busy;
    run_search(4'h9, 0, 2);
    total++;
    if (done_cyc !== 7 || nprobes !== 3) begin
      bad++;
      $display("FAIL busy_start: got done_cyc=%0d probes=%0d want 7 3", done_cyc, nprobes);
    end
    total++;
    if ({FOUND, RESULT, STEPS} !== {1'b1, 4'h9, 3'd3}) begin
      bad++;
      $display("FAIL busy_start result: got found=%b res=%h steps=%0d want 1 9 3", FOUND, RESULT, STEPS);
    end
  endtask

  task automatic test_reset_mid_search;
    target = 4'h9;
    mode   = 0;
    START  = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    total++;
    if (B_OUT !== 4'hB || BUSY !== 1'b1) begin
      bad++;
      $display("FAIL mid_pre: got B=%h busy=%b want B 1", B_OUT, BUSY);
    end
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    total++;
    if ({B_OUT, BUSY, DONE, FOUND, RESULT, STEPS, ERR} !== 15'd0) begin
      bad++;
      $display("FAIL mid_reset: got B=%h busy=%b done=%b found=%b res=%h steps=%0d err=%b, want all 0",
               B_OUT, BUSY, DONE, FOUND, RESULT, STEPS, ERR);
    end
    repeat (6) @(posedge CLK);
    #1;
    total++;
    if (DONE !== 1'b0 || BUSY !== 1'b0) begin
      bad++;
      $display("FAIL mid_no_done: got done=%b busy=%b want 0 0", DONE, BUSY);
    end
    test_find("target5", 4'h5, 3, 32'h735, 7);
  endtask

  task automatic test_flag_conflict;
    run_search(4'h9, 2, -1);
`ifdef SAR_FLAG_CHECK_EN
    total++;
    if ({ERR, DONE, FOUND, STEPS} !== {1'b1, 1'b1, 1'b0, 3'd1} || done_cyc !== 3) begin
      bad++;
      $display("FAIL flag_conflict: got err=%b done=%b found=%b steps=%0d cyc=%0d want 1 1 0 1 3",
               ERR, DONE, FOUND, STEPS, done_cyc);
    end
`else
    total++;
    if (nprobes < 2 || probes[1] !== 4'h3) begin
      bad++;
      $display("FAIL flag_conflict lt_branch: got probes=%0d second=%h want >=2 3", nprobes, probes[1]);
    end
    total++;
    if ({ERR, DONE, FOUND, STEPS} !== {1'b0, 1'b1, 1'b0, 3'd4} || done_cyc !== 9) begin
      bad++;
      $display("FAIL flag_conflict: got err=%b done=%b found=%b steps=%0d cyc=%0d want 0 1 0 4 9",
               ERR, DONE, FOUND, STEPS, done_cyc);
    end
`endif
    // A fresh START clears the fault state.
    run_search(4'h9, 0, -1);
    total++;
    if ({ERR, FOUND, RESULT} !== {1'b0, 1'b1, 4'h9}) begin
      bad++;
      $display("FAIL flag_recover: got err=%b found=%b res=%h want 0 1 9", ERR, FOUND, RESULT);
    end
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    target = 4'h0;
    mode   = 0;
    RST    = 1'b1;
    START  = 1'b0;
    test_reset();
    test_find("target9", 4'h9, 3, 32'h7B9, 7);
    test_find("target0", 4'h0, 4, 32'h7310, 9);
    test_find("targetF", 4'hF, 5, 32'h7BDEF, 11);
    test_always_lt();
    test_start_while_busy();
    test_reset_mid_search();
    test_flag_conflict();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
